// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//   Issue and sequencing controller for the multiply-divide (HI/LO) unit.
//   It launches mult/div ops, counts their fixed latency and pulses the HI/LO
//   commit. It pulses the move-to write for MTLO/MTHI and produces the
//   decode-stage stall for any HI/LO-class instruction while the unit is busy.
//   An exception/interrupt request on the E stage suppresses launches.
//
//   Optional build macro:
//     MD_PERF_EN - adds perf_stall_cnt / perf_op_cnt counters. Both are
//                  32 bits, wrap around, and clear on reset.
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
   parameter int MUL_LAT = 5,   // mult/multu launch-to-commit cycles (>=1)
   parameter int DIV_LAT = 10,  // div/divu launch-to-commit cycles (>=1)
   parameter int CNT_W   = 4    // must hold max(MUL_LAT, DIV_LAT)
) (
   input  logic             clk,
   input  logic             reset,      // asynchronous, active-low
   input  logic [3:0]       e_md_op,
   input  logic             req,
   input  logic             d_md_use,
   output logic             md_start,
   output logic [3:0]       md_op,
   output logic             md_mt_we,
   output logic             md_commit,
   output logic             busy,
   output logic             stall
`ifdef MD_PERF_EN
   ,
   output logic [31:0]      perf_stall_cnt,
   output logic [31:0]      perf_op_cnt
`endif
);

   // ---------------------------------------------------------------------------
   // Op encodings seen on the E stage
   // ---------------------------------------------------------------------------
   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MTHI  = 4'd6;
   localparam logic [3:0] OP_MFLO  = 4'd7;
   localparam logic [3:0] OP_MFHI  = 4'd8;

   localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              is_mul_s;
   logic              is_div_s;
   logic              is_mt_s;
   logic              issue_ok_s;

   // Classify the E-stage op; MF* and the undefined codes 9..15 do nothing here
   always_comb begin
      is_mul_s = 1'b0;
      is_div_s = 1'b0;
      is_mt_s  = 1'b0;
      case (e_md_op)
         OP_MULT, OP_MULTU: is_mul_s = 1'b1;
         OP_DIV,  OP_DIVU:  is_div_s = 1'b1;
         OP_MTLO, OP_MTHI:  is_mt_s  = 1'b1;
         OP_NONE, OP_MFLO, OP_MFHI: begin
            is_mul_s = 1'b0;
         end
         default: begin
            is_mul_s = 1'b0;
         end
      endcase
   end

   // An E-stage op may act only out of reset, with the unit idle and no flush.
   // Gating with reset keeps the combinational pulses low while reset is held.
   assign issue_ok_s = reset & (state_q == IDLE) & ~req;

   // Next-state and output decode for the IDLE/RUN sequencer
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_start  = 1'b0;
      md_mt_we  = 1'b0;
      md_commit = 1'b0;
      md_op     = OP_NONE;
      case (state_q)
         IDLE: begin
            if (issue_ok_s && (is_mul_s || is_div_s)) begin
               md_start = 1'b1;
               md_op    = e_md_op;
               state_d  = RUN;
               cnt_d    = is_mul_s ? MUL_CNT : DIV_CNT;
            end else if (issue_ok_s && is_mt_s) begin
               md_mt_we = 1'b1;
               md_op    = e_md_op;
            end else begin
               state_d  = IDLE;
               cnt_d    = CNT_ZERO;
            end
         end
         RUN: begin
            // Ops arriving here broke the stall contract and are ignored;
            // a request does not cancel an op already in flight.
            if (cnt_q == CNT_ONE) begin
               md_commit = 1'b1;
               cnt_d     = CNT_ZERO;
               state_d   = IDLE;
            end else if (cnt_q == CNT_ZERO) begin
               // Inconsistent state: drop back to IDLE without committing
               cnt_d     = CNT_ZERO;
               state_d   = IDLE;
            end else begin
               cnt_d     = cnt_q - CNT_ONE;
               state_d   = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Sequencer state and latency counter; reset aborts any op in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy  = (state_q == RUN);
   // Stall also covers the launch cycle, so a following HI/LO op in decode waits
   assign stall = d_md_use & (busy | md_start);

`ifdef MD_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_op_q;

   // Free-running stall-cycle and launch counters (wrap naturally)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_q <= 32'd0;
         perf_op_q    <= 32'd0;
      end else begin
         if (stall) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (md_start) begin
            perf_op_q <= perf_op_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_op_cnt    = perf_op_q;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
//   Directed bench for md_issue_ctrl. Inputs change 1 ns after a rising edge.
//   Outputs are sampled on the falling edge, packed as
//   {md_start, md_mt_we, md_commit, busy, stall, md_op}.
//   Define MD_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  e_md_op = 4'd0;
   logic        req = 1'b0;
   logic        d_md_use = 1'b0;
   logic        md_start;
   logic [3:0]  md_op;
   logic        md_mt_we;
   logic        md_commit;
   logic        busy;
   logic        stall;
`ifdef MD_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_op_cnt;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [8:0]  obs_s;

   md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .e_md_op   (e_md_op),
      .req       (req),
      .d_md_use  (d_md_use),
      .md_start  (md_start),
      .md_op     (md_op),
      .md_mt_we  (md_mt_we),
      .md_commit (md_commit),
      .busy      (busy),
      .stall     (stall)
`ifdef MD_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_op_cnt    (perf_op_cnt)
`endif
   );

   always #5 clk = ~clk;

   assign obs_s = {md_start, md_mt_we, md_commit, busy, stall, md_op};

   // Reset held with live stimulus: every output must stay 0
   task automatic test_reset();
      logic [8:0] e;
      e_md_op  = 4'd1;
      d_md_use = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 1) ? 4'd6 : 4'd1;
         @(negedge clk);
         e = 9'd0;
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL reset_hold t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      @(posedge clk); #1;
      e_md_op  = 4'd0;
      d_md_use = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      e = 9'd0;
      checks++;
      if (obs_s !== e) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", obs_s, e);
      end
   endtask

   // MULT: start at T0, busy T1..T5, commit at T5 only
   task automatic test_mult();
      logic [8:0] e;
      for (int t = 0; t < 8; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd1 : 4'd0;
         @(negedge clk);
         e = {t == 0, 1'b0, t == 5, (t >= 1 && t <= 5), 1'b0,
              (t == 0) ? 4'd1 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL mult t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
   endtask

   // DIVU with decode hazard: stall T0..T10, commit at T10
   task automatic test_divu_stall();
      logic [8:0] e;
      d_md_use = 1'b1;
      for (int t = 0; t < 13; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd4 : 4'd0;
         @(negedge clk);
         e = {t == 0, 1'b0, t == 10, (t >= 1 && t <= 10), t <= 10,
              (t == 0) ? 4'd4 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL divu t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      @(posedge clk); #1;
      d_md_use = 1'b0;
   endtask

   // MTHI in IDLE, MTLO ignored mid-MULT, MF* and undefined codes inert
   task automatic test_mt();
      logic [8:0] e;
      logic [3:0] codes [6];
      codes = '{4'd7, 4'd8, 4'd9, 4'd12, 4'd15, 4'd0};
      for (int t = 0; t < 2; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd6 : 4'd0;
         @(negedge clk);
         e = {1'b0, t == 0, 1'b0, 1'b0, 1'b0, (t == 0) ? 4'd6 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL mthi t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      for (int t = 0; t < 7; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd1 : ((t == 2) ? 4'd5 : 4'd0);
         @(negedge clk);
         e = {t == 0, 1'b0, t == 5, (t >= 1 && t <= 5), 1'b0,
              (t == 0) ? 4'd1 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL mtlo_in_run t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         e_md_op = codes[i];
         @(negedge clk);
         e = 9'd0;
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL inert_code code=%0d got=%b exp=%b", codes[i], obs_s, e);
         end
      end
   endtask

   // Request: blocks launch and mt write, but not an op already running
   task automatic test_req();
      logic [8:0] e;
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd3 : ((t == 1) ? 4'd5 : 4'd0);
         req     = (t <= 1);
         @(negedge clk);
         e = 9'd0;
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL req_block t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      for (int t = 0; t < 7; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd1 : 4'd0;
         req     = (t == 3);
         @(negedge clk);
         e = {t == 0, 1'b0, t == 5, (t >= 1 && t <= 5), 1'b0,
              (t == 0) ? 4'd1 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL req_in_run t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      req = 1'b0;
   endtask

   // Reset at T4 of DIV: busy drops at once, no commit ever, then MULT works
   task automatic test_reset_mid();
      logic [8:0] e;
      for (int t = 0; t < 5; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0) ? 4'd3 : 4'd0;
         @(negedge clk);
         e = {t == 0, 1'b0, 1'b0, t >= 1, 1'b0, (t == 0) ? 4'd3 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL div_pre_reset t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      reset = 1'b0;
      #1;
      e = 9'd0;
      checks++;
      if (obs_s !== e) begin
         errors++;
         $display("FAIL async_reset got=%b exp=%b", obs_s, e);
      end
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int t = 0; t < 12; t++) begin
         @(posedge clk); #1;
         e_md_op = 4'd0;
         @(negedge clk);
         e = 9'd0;
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL no_commit_after_reset t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
      test_mult();
   endtask

   // Two MULTs back to back with a hazard in decode; a MULT arriving in the
   // commit cycle is ignored, the next one launches once busy has fallen
   task automatic test_back_to_back();
      logic [8:0] e;
      @(posedge clk); #1;
      reset = 1'b0;
      #3;
      reset = 1'b1;
      d_md_use = 1'b1;
      for (int t = 0; t < 13; t++) begin
         @(posedge clk); #1;
         e_md_op = (t == 0 || t == 5 || t == 6) ? 4'd1 : 4'd0;
         @(negedge clk);
         e = {t == 0 || t == 6, 1'b0, t == 5 || t == 11,
              (t >= 1 && t <= 5) || (t >= 7 && t <= 11), t <= 11,
              (t == 0 || t == 6) ? 4'd1 : 4'd0};
         checks++;
         if (obs_s !== e) begin
            errors++;
            $display("FAIL back_to_back t=%0d got=%b exp=%b", t, obs_s, e);
         end
      end
`ifdef MD_PERF_EN
      checks++;
      if (perf_op_cnt !== 32'd2) begin
         errors++;
         $display("FAIL perf_op_cnt got=%0d exp=2", perf_op_cnt);
      end
      checks++;
      if (perf_stall_cnt !== 32'd12) begin
         errors++;
         $display("FAIL perf_stall_cnt got=%0d exp=12", perf_stall_cnt);
      end
`endif
      @(posedge clk); #1;
      d_md_use = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_divu_stall();
      test_mt();
      test_req();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
